// File: rtl/div_sign_sequencer.sv
// Signed/unsigned front-end and sequencer for the unsigned restoring divider:
// converts operands to magnitudes, starts the divider, restores signs, handles /0 and timeout.
module div_sign_sequencer #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic             in_signed,
    output logic             div_valid_src,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_valid_des,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div_by_zero,
    output logic             out_error
);

    localparam int             CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state;
    logic             sq;
    logic             sr;
    logic [CNT_W-1:0] wd_cnt;
    logic             neg_dd;
    logic             neg_ds;

    // Two's-complement negate; 0x8000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign neg_dd = in_signed & in_dividend[WIDTH-1];
    assign neg_ds = in_signed & in_divisor[WIDTH-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            in_ready        <= 1'b0;
            div_valid_src   <= 1'b0;
            div_dividend    <= '0;
            div_divisor     <= '0;
            out_valid       <= 1'b0;
            out_quotient    <= '0;
            out_remainder   <= '0;
            out_div_by_zero <= 1'b0;
            out_error       <= 1'b0;
            sq              <= 1'b0;
            sr              <= 1'b0;
            wd_cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        sq       <= neg_dd ^ neg_ds;
                        sr       <= neg_dd;
                        if (in_divisor == '0) begin
                            out_valid       <= 1'b1;
                            out_quotient    <= '1;
                            out_remainder   <= in_dividend;
                            out_div_by_zero <= 1'b1;
                            out_error       <= 1'b0;
                            state           <= DONE;
                        end else begin
                            div_dividend  <= neg_if(in_dividend, neg_dd);
                            div_divisor   <= neg_if(in_divisor, neg_ds);
                            div_valid_src <= 1'b1;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    div_valid_src <= 1'b0;
                    wd_cnt        <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    // A done pulse on the timeout cycle still delivers a real result.
                    if (div_valid_des) begin
                        out_quotient  <= neg_if(div_quotient, sq);
                        out_remainder <= neg_if(div_remainder, sr);
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end else if (wd_cnt == TO_LAST) begin
                        out_quotient  <= '0;
                        out_remainder <= '0;
                        out_error     <= 1'b1;
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid       <= 1'b0;
                        out_div_by_zero <= 1'b0;
                        out_error       <= 1'b0;
                        sq              <= 1'b0;
                        sr              <= 1'b0;
                        wd_cnt          <= '0;
                        in_ready        <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
